ram_arbiter: RTL and testbench

- Two-port arbiter that shares the dual-SRAM access subsystem (17-bit word address, bit 16 selects RAM1/RAM2; 16-bit data; en/re/we with done completion) between requester M0 (instruction fetch) and requester M1 (data memory / UART path).
- Sequences one downstream access at a time: grant, issue, wait for done, return data.
- Includes a done-timeout watchdog.
- Sits between the CPU memory stage and the SRAM access subsystem.

---
 rtl/ram_pkg.sv | 30 +++
 rtl/ram_arb_select.sv | 29 ++
 rtl/ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and types for the ram_arbiter slice: FSM state codes,
// SRAM subsystem widths and requester (owner) encoding.
package ram_pkg;

  localparam int unsigned RAM_ADDR_W = 17;
  localparam int unsigned RAM_DATA_W = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } ram_cmd_t;

  function automatic ram_cmd_t pick_cmd(
    input logic     sel,
    input ram_cmd_t cmd0,
    input ram_cmd_t cmd1
  );
    return (sel == OWN_M1) ? cmd1 : cmd0;
  endfunction

endpackage

// File: rtl/ram_arb_select.sv
// Combinational grant selection between M0 and M1.
// RAM_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise M1 has fixed priority.
module ram_arb_select
  import ram_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef RAM_ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant
);

  always_comb begin
    grant = OWN_M0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (req0 && req1) begin
      grant = ~last_grant;
    end else if (req1) begin
      grant = OWN_M1;
    end
`else
    if (req1) begin
      grant = OWN_M1;
    end
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of the dual-SRAM access subsystem with done watchdog.
// Optional RAM_ARB_ROUND_ROBIN_EN switches contention handling to round robin.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [RAM_ADDR_W-1:0] m0_addr,
  input  logic [RAM_DATA_W-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [RAM_DATA_W-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [RAM_ADDR_W-1:0] m1_addr,
  input  logic [RAM_DATA_W-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [RAM_DATA_W-1:0] m1_rdata,

  output logic                  ram_en,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [RAM_DATA_W-1:0] ram_wdata,
  input  logic                  ram_done,
  input  logic [RAM_DATA_W-1:0] ram_rdata
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       state;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             grant;
  logic             start;
  ram_cmd_t         sel_cmd;

  assign start    = (m0_req || m1_req) && !ram_done;
  assign cnt_next = cnt + 1'b1;
  assign sel_cmd  = pick_cmd(grant,
                             '{we: m0_we, addr: m0_addr, wdata: m0_wdata},
                             '{we: m1_we, addr: m1_addr, wdata: m1_wdata});

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_M1;
    end else if (state == IDLE && start) begin
      last_grant <= grant;
    end
  end

  ram_arb_select u_select (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_grant),
    .grant      (grant)
  );
`else
  ram_arb_select u_select (
    .req0  (m0_req),
    .req1  (m1_req),
    .grant (grant)
  );
`endif

  // Strobes are registered on the IDLE->ISSUE edge so they are high for the
  // whole ISSUE/WAIT span and drop on the edge into RESP.
  // The watchdog counts ISSUE and WAIT cycles; timeout fires on the WAIT cycle
  // that brings the count to TIMEOUT_CYCLES, and done in that cycle still wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_M0;
      cnt       <= '0;
      ram_en    <= 1'b0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      m0_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_ack    <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            owner     <= grant;
            ram_addr  <= sel_cmd.addr;
            ram_wdata <= sel_cmd.wdata;
            ram_en    <= 1'b1;
            ram_re    <= ~sel_cmd.we;
            ram_we    <= sel_cmd.we;
            cnt       <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= cnt_next;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_next;
          if (ram_done || cnt_next >= TIMEOUT_CNT) begin
            if (ram_done && !ram_we) begin
              if (owner == OWN_M1) begin
                m1_rdata <= ram_rdata;
              end else begin
                m0_rdata <= ram_rdata;
              end
            end
            m0_ack <= (owner == OWN_M0);
            m1_ack <= (owner == OWN_M1);
            m0_err <= (owner == OWN_M0) && !ram_done;
            m1_err <= (owner == OWN_M1) && !ram_done;
            ram_en <= 1'b0;
            ram_re <= 1'b0;
            ram_we <= 1'b0;
            state  <= RESP;
          end
        end
        RESP: begin
          m0_ack <= 1'b0;
          m0_err <= 1'b0;
          m1_ack <= 1'b0;
          m1_err <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (TIMEOUT_CYCLES = 4).
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_ack, m0_err;
  logic [16:0] m0_addr;
  logic [15:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack, m1_err;
  logic [16:0] m1_addr;
  logic [15:0] m1_wdata, m1_rdata;
  logic        ram_en, ram_re, ram_we, ram_done;
  logic [16:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_done(ram_done), .ram_rdata(ram_rdata)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    ram_done = 0; ram_rdata = '0;
    step(2);
    checks++;
    if ({ram_en, ram_re, ram_we} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000", {ram_en, ram_re, ram_we});
    end
    checks++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_acks: got %b expected 0000", {m0_ack, m0_err, m1_ack, m1_err});
    end
    checks++;
    if ({ram_addr, ram_wdata, m0_rdata, m1_rdata} !== 65'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h expected all 0", ram_addr, ram_wdata, m0_rdata, m1_rdata);
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_m0_read;
    m0_addr = 17'h00010; m0_we = 0; m0_req = 1;
    step(1);
    checks++;
    if ({ram_en, ram_re, ram_we} !== 3'b110 || ram_addr !== 17'h00010) begin
      errors++; $display("FAIL m0_read_issue: got en/re/we=%b addr=%h expected 110 00010", {ram_en, ram_re, ram_we}, ram_addr);
    end
    step(1);
    checks++;
    if ({ram_en, ram_re, ram_we} !== 3'b110 || m0_ack !== 1'b0) begin
      errors++; $display("FAIL m0_read_wait: got en/re/we=%b ack=%b expected 110 0", {ram_en, ram_re, ram_we}, m0_ack);
    end
    ram_done = 1; ram_rdata = 16'hBEEF;
    step(1);
    checks++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL m0_read_ack: got ack=%b err=%b rdata=%h expected 1 0 beef", m0_ack, m0_err, m0_rdata);
    end
    checks++;
    if (ram_en !== 1'b0 || m1_ack !== 1'b0) begin
      errors++; $display("FAIL m0_read_resp: got en=%b m1_ack=%b expected 0 0", ram_en, m1_ack);
    end
    m0_req = 0; ram_done = 0; ram_rdata = '0;
    step(1);
    checks++;
    if (m0_ack !== 1'b0 || m0_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL m0_read_after: got ack=%b rdata=%h expected 0 beef", m0_ack, m0_rdata);
    end
  endtask

  task automatic test_m1_write;
    m1_addr = 17'h1_0004; m1_wdata = 16'h1234; m1_we = 1; m1_req = 1;
    step(1);
    checks++;
    if ({ram_en, ram_re, ram_we} !== 3'b101 || ram_addr !== 17'h1_0004 || ram_wdata !== 16'h1234) begin
      errors++; $display("FAIL m1_write_issue: got en/re/we=%b addr=%h wdata=%h expected 101 10004 1234", {ram_en, ram_re, ram_we}, ram_addr, ram_wdata);
    end
    step(2);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 17'h1_0004 || ram_wdata !== 16'h1234 || m1_ack !== 1'b0) begin
      errors++; $display("FAIL m1_write_hold: got we=%b addr=%h wdata=%h ack=%b expected 1 10004 1234 0", ram_we, ram_addr, ram_wdata, m1_ack);
    end
    ram_done = 1; ram_rdata = 16'hDEAD;
    step(1);
    checks++;
    if (m1_ack !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== 16'h0000) begin
      errors++; $display("FAIL m1_write_ack: got ack=%b err=%b rdata=%h expected 1 0 0000", m1_ack, m1_err, m1_rdata);
    end
    checks++;
    if (m0_ack !== 1'b0 || m0_rdata !== 16'hBEEF || ram_we !== 1'b0) begin
      errors++; $display("FAIL m1_write_side: got m0_ack=%b m0_rdata=%h ram_we=%b expected 0 beef 0", m0_ack, m0_rdata, ram_we);
    end
    m1_req = 0; m1_we = 0; ram_done = 0; ram_rdata = '0;
    step(1);
    checks++;
    if (m1_ack !== 1'b0) begin
      errors++; $display("FAIL m1_write_pulse: got ack=%b expected 0", m1_ack);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp_seq;
    logic       exp_own;
    int         t;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_seq = 3'b010;
`else
    exp_seq = 3'b111;
`endif
    rst = 1; step(1); rst = 0;
    m0_addr = 17'h00100; m0_we = 0; m1_addr = 17'h1_0200; m1_we = 0;
    m0_req = 1; m1_req = 1;
    for (int k = 0; k < 3; k++) begin
      exp_own = exp_seq[k];
      t = 0;
      while (ram_en !== 1'b1 && t < 10) begin
        step(1); t++;
      end
      checks++;
      if (ram_en !== 1'b1) begin
        errors++; $display("FAIL b2b_grant_%0d: got no ram_en within 10 cycles, expected ram_en=1", k);
      end
      checks++;
      if (ram_addr !== (exp_own ? 17'h1_0200 : 17'h00100)) begin
        errors++; $display("FAIL b2b_owner_%0d: got addr=%h expected owner M%0d", k, ram_addr, exp_own);
      end
      step(1);
      ram_done = 1; ram_rdata = 16'hA000 + 16'(k);
      step(1);
      checks++;
      if (m0_ack !== ~exp_own || m1_ack !== exp_own) begin
        errors++; $display("FAIL b2b_ack_%0d: got m0_ack=%b m1_ack=%b expected M%0d acked", k, m0_ack, m1_ack, exp_own);
      end
      ram_done = 0;
    end
    m0_req = 0; m1_req = 0;
    step(2);
  endtask

  task automatic test_timeout;
    // done arriving on the timeout cycle counts as success
    m0_addr = 17'h00020; m0_we = 0; m0_req = 1;
    step(1);
    step(3);
    checks++;
    if (ram_en !== 1'b1 || m0_ack !== 1'b0) begin
      errors++; $display("FAIL tmo_edge_wait: got en=%b ack=%b expected 1 0", ram_en, m0_ack);
    end
    ram_done = 1; ram_rdata = 16'h5A5A;
    step(1);
    checks++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 16'h5A5A) begin
      errors++; $display("FAIL tmo_edge_done: got ack=%b err=%b rdata=%h expected 1 0 5a5a", m0_ack, m0_err, m0_rdata);
    end
    m0_req = 0; ram_done = 0; ram_rdata = '0;
    step(1);
    m0_addr = 17'h00024; m0_req = 1;
    step(1);
    checks++;
    if (ram_en !== 1'b1) begin
      errors++; $display("FAIL tmo_issue: got en=%b expected 1", ram_en);
    end
    step(3);
    checks++;
    if (ram_en !== 1'b1 || m0_ack !== 1'b0) begin
      errors++; $display("FAIL tmo_before: got en=%b ack=%b expected 1 0", ram_en, m0_ack);
    end
    step(1);
    checks++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 16'h5A5A) begin
      errors++; $display("FAIL tmo_abort: got ack=%b err=%b rdata=%h expected 1 1 5a5a", m0_ack, m0_err, m0_rdata);
    end
    checks++;
    if (ram_en !== 1'b0 || m1_ack !== 1'b0 || m1_err !== 1'b0) begin
      errors++; $display("FAIL tmo_resp: got en=%b m1_ack=%b m1_err=%b expected 0 0 0", ram_en, m1_ack, m1_err);
    end
    m0_req = 0;
    step(1);
    checks++;
    if (m0_ack !== 1'b0 || m0_err !== 1'b0) begin
      errors++; $display("FAIL tmo_pulse: got ack=%b err=%b expected 0 0", m0_ack, m0_err);
    end
    m1_addr = 17'h00042; m1_we = 0; m1_req = 1;
    step(1);
    step(1);
    ram_done = 1; ram_rdata = 16'h0F0F;
    step(1);
    checks++;
    if (m1_ack !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== 16'h0F0F) begin
      errors++; $display("FAIL tmo_recover: got ack=%b err=%b rdata=%h expected 1 0 0f0f", m1_ack, m1_err, m1_rdata);
    end
    m1_req = 0; ram_done = 0; ram_rdata = '0;
    step(1);
  endtask

  task automatic test_stale_done;
    m0_addr = 17'h00030; m0_we = 0; m0_req = 1;
    step(2);
    ram_done = 1; ram_rdata = 16'h1111;
    step(1);
    checks++;
    if (m0_ack !== 1'b1 || m0_rdata !== 16'h1111) begin
      errors++; $display("FAIL stale_first: got ack=%b rdata=%h expected 1 1111", m0_ack, m0_rdata);
    end
    step(1);
    checks++;
    if (ram_en !== 1'b0) begin
      errors++; $display("FAIL stale_hold1: got en=%b expected 0", ram_en);
    end
    step(1);
    checks++;
    if (ram_en !== 1'b0) begin
      errors++; $display("FAIL stale_hold2: got en=%b expected 0", ram_en);
    end
    ram_done = 0;
    step(1);
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== 17'h00030) begin
      errors++; $display("FAIL stale_issue: got en=%b addr=%h expected 1 00030", ram_en, ram_addr);
    end
    step(1);
    ram_done = 1; ram_rdata = 16'h2222;
    step(1);
    checks++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 16'h2222) begin
      errors++; $display("FAIL stale_second: got ack=%b err=%b rdata=%h expected 1 0 2222", m0_ack, m0_err, m0_rdata);
    end
    m0_req = 0; ram_done = 0; ram_rdata = '0;
    step(1);
  endtask

  task automatic test_reset_mid;
    m1_addr = 17'h1_0077; m1_we = 0; m1_req = 1;
    step(2);
    rst = 1;
    step(1);
    checks++;
    if ({ram_en, ram_re, ram_we, m0_ack, m0_err, m1_ack, m1_err} !== 7'd0 ||
        {ram_addr, ram_wdata, m0_rdata, m1_rdata} !== 65'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got en=%b acks=%b addr=%h rdata=%h/%h expected all 0",
                         ram_en, {m0_ack, m1_ack}, ram_addr, m0_rdata, m1_rdata);
    end
    rst = 0; m1_req = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if ({ram_en, m0_ack, m1_ack} !== 3'b000) begin
        errors++; $display("FAIL rst_mid_quiet_%0d: got en/ack0/ack1=%b expected 000", i, {ram_en, m0_ack, m1_ack});
      end
    end
    m0_addr = 17'h00055; m0_req = 1;
    step(1);
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== 17'h00055) begin
      errors++; $display("FAIL rst_mid_restart: got en=%b addr=%h expected 1 00055", ram_en, ram_addr);
    end
    step(1);
    ram_done = 1; ram_rdata = 16'h7777;
    step(1);
    checks++;
    if (m0_ack !== 1'b1 || m0_rdata !== 16'h7777) begin
      errors++; $display("FAIL rst_mid_complete: got ack=%b rdata=%h expected 1 7777", m0_ack, m0_rdata);
    end
    m0_req = 0; ram_done = 0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_m0_read;
    test_m1_write;
    test_back_to_back;
    test_timeout;
    test_stale_done;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
